// File: rtl/iob_spi_slave_pkg.sv
// Shared constants and types for the iob_spi_slave SPI responder.
package iob_spi_slave_pkg;

  localparam int         DATA_W_DEF      = 8;
  localparam int         SYNC_STAGES_DEF = 2;
  localparam logic [7:0] TX_IDLE_DEF     = 8'hFF;

  // Mode encodings are {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/iob_spi_slave_edge.sv
// Synchronizer for one asynchronous SPI pin with rise/fall pulses
// taken from the synced value against a one-cycle-delayed copy.
module iob_spi_slave_edge
  import iob_spi_slave_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cur;

  assign cur = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= cur;
    end
  end

  assign rise_o = cur & ~prev_q;
  assign fall_o = ~cur & prev_q;

endmodule

// File: rtl/iob_spi_slave.sv
// Single-lane SPI responder: oversampled SCLK/SS/MOSI, one-entry
// RX and TX buffers, all four CPOL/CPHA modes, sticky status flags.
module iob_spi_slave
  import iob_spi_slave_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(TX_IDLE_DEF)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic              cpol_i,
  input  logic              cpha_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              underrun_o,
  input  logic              clr_flags_i
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;

  iob_spi_slave_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sclk_edge (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (sclk_i),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  iob_spi_slave_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_ss_edge (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (ss_n_i),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  spi_mode_t         mode_q, mode_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              load_pend_q, load_pend_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ovr_q, ovr_d;
  logic              udr_q, udr_d;

  logic              sample_raw, shift_raw;
  logic              sample_ev, shift_ev;
  logic              frame_start, frame_end;
  logic              word_done, do_load;
  logic              tx_wr, rx_push, rx_drop;
  logic [DATA_W-1:0] rx_word;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  // Leading edge leaves the CPOL idle level; CPHA picks which one samples.
  always_comb begin
    sample_raw = 1'b0;
    shift_raw  = 1'b0;
    unique case (mode_q)
      MODE0: begin sample_raw = sclk_rise; shift_raw = sclk_fall; end
      MODE1: begin sample_raw = sclk_fall; shift_raw = sclk_rise; end
      MODE2: begin sample_raw = sclk_fall; shift_raw = sclk_rise; end
      MODE3: begin sample_raw = sclk_rise; shift_raw = sclk_fall; end
      default: ;
    endcase
  end

  assign frame_start = ss_fall;
  assign frame_end   = ss_rise & busy_q;
  assign sample_ev   = busy_q & sample_raw;
  assign shift_ev    = busy_q & shift_raw;
  assign word_done   = sample_ev & (bit_cnt_q == LAST_BIT);
  assign rx_word     = {rx_shift_q[DATA_W-2:0], mosi_s};
  assign do_load     = (frame_start & ~cpha_i) | (shift_ev & load_pend_q);
  assign tx_wr       = tx_valid_i & ~tx_full_q;
  assign rx_push     = word_done & (~rx_valid_q | rx_ready_i);
  assign rx_drop     = word_done & rx_valid_q & ~rx_ready_i;

  always_comb begin
    mode_d      = mode_q;
    busy_d      = busy_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    load_pend_d = load_pend_q;
    tx_shift_d  = tx_shift_q;

    if (frame_start) begin
      mode_d = '{cpol: cpol_i, cpha: cpha_i};
      busy_d = 1'b1;
    end else if (frame_end) begin
      busy_d = 1'b0;
    end

    if (sample_ev) begin
      rx_shift_d = rx_word;
    end

    if (frame_start || frame_end || word_done) begin
      bit_cnt_d = '0;
    end else if (sample_ev) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (frame_end) begin
      load_pend_d = 1'b0;
    end else if (frame_start) begin
      load_pend_d = cpha_i;
    end else if (word_done) begin
      load_pend_d = 1'b1;
    end else if (shift_ev) begin
      load_pend_d = 1'b0;
    end

    if (do_load) begin
      tx_shift_d = tx_full_q ? tx_buf_q : TX_IDLE;
    end else if (shift_ev) begin
      tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  // A write landing in the load cycle goes to the buffer, not the load.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    if (do_load) begin
      tx_full_d = 1'b0;
    end
    if (tx_wr) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data_i;
    end
  end

  always_comb begin
    rx_data_d  = rx_push ? rx_word : rx_data_q;
    rx_valid_d = rx_push | (rx_valid_q & ~rx_ready_i);
    ovr_d      = rx_drop | (ovr_q & ~clr_flags_i);
    udr_d      = (do_load & ~tx_full_q) | (udr_q & ~clr_flags_i);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mode_q      <= '0;
      busy_q      <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      load_pend_q <= 1'b0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      load_pend_q <= load_pend_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      udr_q       <= udr_d;
    end
  end

  assign miso_o     = busy_q ? tx_shift_q[DATA_W-1] : 1'b1;
  assign miso_oe_o  = busy_q;
  assign busy_o     = busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = ~tx_full_q;
  assign overrun_o  = ovr_q;
  assign underrun_o = udr_q;

endmodule

// File: tb/tb_iob_spi_slave.sv
// Bench for iob_spi_slave: SPI master model, TX producer, RX
// scoreboard and steady-state frame monitor.
module tb_iob_spi_slave;

  logic       clk = 1'b0;
  logic       arst_i = 1'b1;
  logic       sclk_i = 1'b0;
  logic       ss_n_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic       rx_ready_i = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       clr_flags_i = 1'b0;
  logic       miso_o, miso_oe_o, rx_valid_o;
  logic       tx_ready_o, busy_o, overrun_o, underrun_o;
  logic [7:0] rx_data_o;

  int         checks = 0;
  int         passes = 0;
  int         rises = 0;
  int         ss_cnt = 0;
  logic       prev_v = 1'b0;
  logic       ss_prev = 1'b1;
  logic [7:0] exp_q[$];

  iob_spi_slave dut (
    .clk_i       (clk),
    .arst_i      (arst_i),
    .sclk_i      (sclk_i),
    .ss_n_i      (ss_n_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .cpol_i      (cpol_i),
    .cpha_i      (cpha_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .underrun_o  (underrun_o),
    .clr_flags_i (clr_flags_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run still going at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Sampled just before each rising edge, after inputs settled.
  always @(negedge clk) begin
    #3;
    if (arst_i) begin
      ss_cnt = 0;
      prev_v = 1'b0;
    end else begin
      if (rx_valid_o && !prev_v) rises++;
      prev_v = rx_valid_o;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) chk("rx_unexpected", rx_data_o, 32'hFFFF_FFFF);
        else chk("rx_word", rx_data_o, exp_q.pop_front());
      end
      if (ss_n_i != ss_prev) ss_cnt = 0;
      else if (ss_cnt < 100) ss_cnt++;
      ss_prev = ss_n_i;
      if (ss_cnt >= 5) begin
        chk("busy_steady", busy_o, !ss_n_i);
        chk("oe_steady", miso_oe_o, !ss_n_i);
        if (ss_n_i) chk("miso_idle", miso_o, 1);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_miso"}, miso_o, 1);
    chk({tag, "_oe"}, miso_oe_o, 0);
    chk({tag, "_rx_data"}, rx_data_o, 0);
    chk({tag, "_rx_valid"}, rx_valid_o, 0);
    chk({tag, "_tx_ready"}, tx_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
    chk({tag, "_underrun"}, underrun_o, 0);
  endtask

  task automatic clr_flags();
    @(negedge clk);
    clr_flags_i = 1'b1;
    @(negedge clk);
    clr_flags_i = 1'b0;
  endtask

  // Producer: word i sits in w[8*i +: 8].
  task automatic feed(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int t = 0; t < 3000 && !tx_ready_o; t++) @(negedge clk);
      chk("tx_ready_wait", tx_ready_o, 1);
      tx_data_i  = w[8*i +: 8];
      tx_valid_i = 1'b1;
      @(negedge clk);
      tx_valid_i = 1'b0;
    end
  endtask

  task automatic half_wait(input logic pulse);
    if (pulse) begin
      repeat (2) @(negedge clk);
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // SPI master at f_clk/8; MSB first; captures MISO on sample edges.
  task automatic spi_frame(input logic [1:0] md, input int nwords,
                           input int nbits, input logic raise_ss,
                           input logic [31:0] mo, input int pulse_k,
                           output logic [31:0] mi);
    int nb;
    int ix;
    mi = '0;
    nb = nwords * 8;
    cpol_i = md[1];
    cpha_i = md[0];
    sclk_i = md[1];
    repeat (4) @(negedge clk);
    ss_n_i = 1'b0;
    if (!md[0]) mosi_i = mo[7];
    repeat (6) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      ix = (k / 8) * 8 + 7 - (k % 8);
      if (!md[0]) mi[ix] = miso_o;
      else mosi_i = mo[ix];
      sclk_i = ~sclk_i;
      half_wait(!md[0] && k == pulse_k);
      if (md[0]) mi[ix] = miso_o;
      else if (k + 1 < nb) mosi_i = mo[((k+1)/8)*8 + 7 - ((k+1)%8)];
      sclk_i = ~sclk_i;
      half_wait(md[0] && k == pulse_k);
    end
    if (raise_ss) begin
      ss_n_i = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  logic [31:0] mi;
  int          r0;

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    arst_i = 1'b0;
    repeat (4) @(negedge clk);
    check_reset("rst_rel");

    // Mode 0, single word; final trailing load finds the buffer empty.
    clr_flags();
    feed(32'hA5, 1);
    @(negedge clk);
    chk("t1_tx_full", tx_ready_o, 0);
    r0 = rises;
    exp_q.push_back(8'h3C);
    spi_frame(2'b00, 1, 8, 1'b1, 32'h3C, -1, mi);
    chk("t1_miso", mi[7:0], 8'hA5);
    chk("t1_rx_data", rx_data_o, 8'h3C);
    chk("t1_rises", rises - r0, 1);
    chk("t1_tx_ready", tx_ready_o, 1);
    chk("t1_underrun", underrun_o, 1);
    chk("t1_overrun", overrun_o, 0);

    // Modes 1..3, two words; CPHA=0 needs one extra word for its last load.
    for (int m = 1; m < 4; m++) begin
      logic [1:0] md;
      md = 2'(m);
      clr_flags();
      feed(32'h81, 1);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h5A);
      fork
        spi_frame(md, 2, 16, 1'b1, 32'h5AC3, -1, mi);
        feed(32'h007E, md[0] ? 1 : 2);
      join
      chk("t2_miso", mi[15:0], 16'h7E81);
      chk("t2_rx_last", rx_data_o, 8'h5A);
      chk("t2_overrun", overrun_o, 0);
      chk("t2_underrun", underrun_o, 0);
      chk("t2_tx_ready", tx_ready_o, 1);
    end

    // No TX data at all.
    clr_flags();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    spi_frame(2'b01, 2, 16, 1'b1, 32'h3412, -1, mi);
    chk("t3_miso", mi[15:0], 16'hFFFF);
    chk("t3_underrun", underrun_o, 1);
    clr_flags();
    chk("t3_underrun_clr", underrun_o, 0);

    // Consumer stalled over two words: second word dropped.
    clr_flags();
    rx_ready_i = 1'b0;
    exp_q.push_back(8'h11);
    spi_frame(2'b00, 2, 16, 1'b1, 32'h2211, -1, mi);
    chk("t4_rx_data", rx_data_o, 8'h11);
    chk("t4_rx_valid", rx_valid_o, 1);
    chk("t4_overrun", overrun_o, 1);
    rx_ready_i = 1'b1;
    repeat (2) @(negedge clk);

    // Ready pulsed exactly in the completion cycle: pop and push together.
    clr_flags();
    rx_ready_i = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    spi_frame(2'b00, 2, 16, 1'b1, 32'h2211, 15, mi);
    chk("t4b_rx_data", rx_data_o, 8'h22);
    chk("t4b_rx_valid", rx_valid_o, 1);
    chk("t4b_overrun", overrun_o, 0);
    rx_ready_i = 1'b1;
    repeat (2) @(negedge clk);

    // Frame aborted after 5 bits, then a clean frame.
    r0 = rises;
    spi_frame(2'b00, 1, 5, 1'b1, 32'hAB, -1, mi);
    chk("t5_oe_between", miso_oe_o, 0);
    chk("t5_busy_between", busy_o, 0);
    chk("t5_rx_valid_between", rx_valid_o, 0);
    exp_q.push_back(8'hF0);
    spi_frame(2'b00, 1, 8, 1'b1, 32'hF0, -1, mi);
    chk("t5_rx_data", rx_data_o, 8'hF0);
    chk("t5_rises", rises - r0, 1);

    // Reset in the middle of a word.
    clr_flags();
    feed(32'h5A, 1);
    spi_frame(2'b00, 1, 3, 1'b0, 32'h55, -1, mi);
    arst_i = 1'b1;
    #1;
    check_reset("rst_mid");
    ss_n_i = 1'b1;
    sclk_i = 1'b0;
    mosi_i = 1'b0;
    repeat (3) @(negedge clk);
    arst_i = 1'b0;
    repeat (4) @(negedge clk);
    feed(32'h69, 1);
    exp_q.push_back(8'h96);
    spi_frame(2'b00, 1, 8, 1'b1, 32'h96, -1, mi);
    chk("t6_miso", mi[7:0], 8'h69);
    chk("t6_rx_data", rx_data_o, 8'h96);

    repeat (4) @(negedge clk);
    chk("rx_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
